// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the five-stage pipeline.
//
// Decides each cycle whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance,
// hold or take a bubble. Handles three cases:
//   - multi-cycle data-memory access, with a forced release after MEM_TIMEOUT
//     stalled cycles (highest priority),
//   - EX-stage redirects (taken branch, JAL, JALR),
//   - load-use hazards (a one-cycle stall).
//
// Parameters:
//   MEM_TIMEOUT   max stalled cycles for one data access (1..255)
// Optional feature:
//   HAZ_PERF_CNT_EN  when defined, stall_cycles / flush_events count cycles
//                    with pc_en = 0 / if_id_flush = 1; otherwise both are 0.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_rs1/id_rs2, id_uses_*    ID-stage source registers and their use flags
//   ex_rd, ex_mem_read          EX-stage destination and "is a load"
//   ex_redirect                 EX resolved a taken branch / JAL / JALR
//   mem_access, dmem_ready      MEM-stage load/store and memory completion
//   dmem_req                    data-memory request strobe
//   pc_en, *_en                 pipeline register update enables
//   if_id_flush, id_ex_flush    bubble insertion into IF/ID, ID/EX
//   mem_wb_bubble               MEM/WB captures a non-writing bubble
//   mem_timeout                 one-cycle pulse: access abandoned
//   stall_cycles, flush_events  performance counters
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_redirect,
   input  logic        mem_access,
   input  logic        dmem_ready,
   output logic        dmem_req,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_en,
   output logic        id_ex_flush,
   output logic        ex_mem_en,
   output logic        mem_wb_bubble,
   output logic        mem_timeout,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          mstall, timeout, load_use;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // wait_cnt holds the number of stalled cycles already spent on the
   // current access, so reaching MEM_TIMEOUT means the budget is used up
   // and this cycle becomes the forced release.
   always_comb begin
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
      mstall       = 1'b0;
      timeout      = 1'b0;
      case (state)
         RUN: begin
            if (mem_access && !dmem_ready) begin
               mstall       = 1'b1;
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = CW'(1);
            end
         end
         MEM_WAIT: begin
            // ready (or the access going away) releases; ready beats timeout
            if (mem_access && !dmem_ready) begin
               if (wait_cnt == TIMEOUT_VAL) begin
                  timeout = 1'b1;
               end else begin
                  mstall       = 1'b1;
                  state_nxt    = MEM_WAIT;
                  wait_cnt_nxt = wait_cnt + CW'(1);
               end
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   // Priority: mstall > redirect > load-use > normal. A redirect squashes the
   // ID instruction, so its load-use match is irrelevant.
   always_comb begin
      dmem_req      = mem_access;
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_en     = 1'b1;
      mem_wb_bubble = timeout;   // abandoned access must not write back
      mem_timeout   = timeout;
      if (reset) begin
         dmem_req      = 1'b0;
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_en      = 1'b0;
         id_ex_flush   = 1'b1;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
         mem_timeout   = 1'b0;
      end else if (mstall) begin
         // freeze everything; a pending redirect waits in the frozen EX stage
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_en)      stall_cycles <= stall_cycles + 32'd1;
         if (if_id_flush) flush_events <= flush_events + 32'd1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4). The driver applies
// stimulus after each rising edge, evaluates a reference model built from the
// hazard rules and pushes the expected outputs; the monitor pops and compares
// on the falling edge.
module tb_pipe_hazard_ctrl;

   localparam int TO = 4;

   typedef struct packed {
      logic       reset;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] ex_rd;
      logic       mem_read, redirect, mem_access, ready;
   } stim_t;

   typedef struct {
      logic [8:0]  ctrl;  // dmem_req,pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem,bubble,timeout
      logic [31:0] stalls;
      logic [31:0] flushes;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_redirect = 0;
   logic mem_access = 0, dmem_ready = 0;
   logic dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic ex_mem_en, mem_wb_bubble, mem_timeout;
   logic [31:0] stall_cycles, flush_events;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en),
      .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
      .ex_mem_en(ex_mem_en), .mem_wb_bubble(mem_wb_bubble),
      .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // reference model state: are we mid-access, and how many stalls so far
   bit          m_waiting = 0;
   int          m_waited  = 0;
   logic [31:0] m_stalls  = '0;
   logic [31:0] m_flushes = '0;

   task automatic step(input stim_t s);
      exp_t e;
      bit hit, busy, tmo, mst;
      logic pc, ifen, iffl, idexen, idexfl, exm, bub;
      @(posedge clk);
      #1;
      reset = s.reset; id_rs1 = s.rs1; id_rs2 = s.rs2;
      id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_rd = s.ex_rd;
      ex_mem_read = s.mem_read; ex_redirect = s.redirect;
      mem_access = s.mem_access; dmem_ready = s.ready;
      e.stalls  = m_stalls;
      e.flushes = m_flushes;
      if (s.reset) begin
         e.ctrl = 9'b0_0_0_1_0_1_0_1_0;
         m_waiting = 0; m_waited = 0; m_stalls = '0; m_flushes = '0;
      end else begin
         hit  = s.mem_read && s.ex_rd != 0 &&
                ((s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd));
         busy = s.mem_access && !s.ready;
         tmo  = busy && m_waiting && m_waited == TO;
         mst  = busy && !tmo;
         pc = 1; ifen = 1; iffl = 0; idexen = 1; idexfl = 0; exm = 1; bub = tmo;
         if (mst) begin
            pc = 0; ifen = 0; idexen = 0; exm = 0; bub = 1;
         end else if (s.redirect) begin
            iffl = 1; idexfl = 1;
         end else if (hit) begin
            pc = 0; ifen = 0; idexfl = 1;
         end
         e.ctrl = {s.mem_access, pc, ifen, iffl, idexen, idexfl, exm, bub, tmo};
         if (mst) begin
            m_waited  = m_waiting ? m_waited + 1 : 1;
            m_waiting = 1;
         end else begin
            m_waiting = 0; m_waited = 0;
         end
         if (!pc)  m_stalls  = m_stalls + 32'd1;
         if (iffl) m_flushes = m_flushes + 32'd1;
      end
      q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("ctrl", 32'({dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
                            id_ex_flush, ex_mem_en, mem_wb_bubble, mem_timeout}),
               32'(e.ctrl));
`ifdef HAZ_PERF_CNT_EN
         check("stall_cycles", stall_cycles, e.stalls);
         check("flush_events", flush_events, e.flushes);
`else
         check("stall_cycles", stall_cycles, 32'd0);
         check("flush_events", flush_events, 32'd0);
`endif
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   initial begin
      stim_t s;
      // reset state
      s = idle(); s.reset = 1;
      step(s); step(s);
      // load-use: one stall, then the bubble clears it
      s = idle(); s.mem_read = 1; s.ex_rd = 5; s.rs1 = 5; s.u1 = 1;
      step(s);
      s.mem_read = 0; s.ex_rd = 0;
      step(s);
      // ex_rd = 0 never stalls; rs2 match does
      s = idle(); s.mem_read = 1; s.ex_rd = 0; s.rs1 = 0; s.u1 = 1;
      step(s);
      s = idle(); s.mem_read = 1; s.ex_rd = 7; s.rs2 = 7; s.u2 = 1;
      step(s);
      // unused operand does not stall
      s.u2 = 0; step(s);
      // redirect beats load-use
      s = idle(); s.mem_read = 1; s.ex_rd = 5; s.rs1 = 5; s.u1 = 1; s.redirect = 1;
      step(s);
      step(idle());
      // memory wait: ready after 3 cycles
      s = idle(); s.mem_access = 1;
      repeat (3) step(s);
      s.ready = 1; step(s);
      step(idle());
      // timeout: never ready
      s = idle(); s.mem_access = 1;
      repeat (5) step(s);
      step(idle());
      // timeout variant: ready on the would-be release cycle
      s = idle(); s.mem_access = 1;
      repeat (4) step(s);
      s.ready = 1; step(s);
      step(idle());
      // redirect held during mstall
      s = idle(); s.mem_access = 1; s.redirect = 1;
      repeat (2) step(s);
      s.ready = 1; step(s);
      step(idle());
      // reset in the middle of a wait
      s = idle(); s.mem_access = 1;
      repeat (3) step(s);
      s.reset = 1; step(s);
      s.reset = 0; s.ready = 1; step(s);
      step(idle());
      // randomized traffic; a frozen MEM stage keeps presenting its access
      for (int i = 0; i < 3000; i++) begin
         s.reset    = ($urandom_range(99) < 2);
         s.rs1      = 5'($urandom_range(3));
         s.rs2      = 5'($urandom_range(3));
         s.ex_rd    = 5'($urandom_range(3));
         s.u1       = 1'($urandom_range(1));
         s.u2       = 1'($urandom_range(1));
         s.mem_read = ($urandom_range(99) < 40);
         s.redirect = ($urandom_range(99) < 15);
         s.mem_access = m_waiting ? 1'b1 : ($urandom_range(99) < 30);
         s.ready    = ($urandom_range(99) < 40);
         step(s);
      end
      // drain the scoreboard, bounded
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. It decides each cycle whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold, or take a bubble. It covers three cases: load-use hazards, EX-stage redirects (taken branch, JAL, JALR), and a multi-cycle data-memory handshake with timeout. It sits beside the pipeline registers and drives their enable and flush inputs.

## Interface
- MEM_TIMEOUT, 15: maximum stalled cycles for one data-memory access before forced release; legal range 1..255.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination of the instruction in EX (ID/EX output).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- mem_access  in  1  instruction in MEM is a valid load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request strobe.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID update enable.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_en  out  1  ID/EX update enable.
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0).
- ex_mem_en  out  1  EX/MEM update enable.
- mem_wb_bubble  out  1  MEM/WB captures reg_write=0, mem_to_reg=0.
- mem_timeout  out  1  one-cycle pulse: access abandoned.
- stall_cycles  out  32  performance counter (see Configuration).
- flush_events  out  32  performance counter (see Configuration).

## Operation
- **State register:** FSM states RUN and MEM_WAIT, plus wait_cnt of width $clog2(MEM_TIMEOUT+1). All outputs are combinational from state and inputs.
- **dmem_req:** equals mem_access in both states.
- **Memory stall condition (mstall):** mem_access & !dmem_ready, unless timeout fires (below).
  - While mstall: pc_en = if_id_en = id_ex_en = ex_mem_en = 0, and mem_wb_bubble = 1.
  - No flush outputs assert during mstall; a pending ex_redirect is held because EX is frozen.
- **RUN state:**
  - mstall → go to MEM_WAIT, wait_cnt = 1.
  - Access completes with ready in the same cycle → zero stall.
- **MEM_WAIT state:**
  - dmem_ready → release, return to RUN, wait_cnt = 0.
  - Else if wait_cnt == MEM_TIMEOUT → timeout release: mem_timeout = 1, stages advance, mem_wb_bubble = 1, return to RUN.
  - Else → wait_cnt + 1.
  - dmem_ready and the timeout condition in the same cycle: ready wins, no mem_timeout.
- **Redirect** (ex_redirect & !mstall): if_id_flush = 1, id_ex_flush = 1, all enables = 1.
- **Load-use** (ex_mem_read & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)), with no mstall and no redirect):
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_mem_en = 1.
- **Priority:** mstall > redirect > load-use > normal.
  - A redirect suppresses the load-use stall, because the ID instruction is squashed.
- **Normal operation:** all enables = 1, flushes = 0, mem_wb_bubble = 0.

## Timing
- **Reset (while asserted):**
  - State = RUN, wait_cnt = 0, counters = 0.
  - Outputs forced: pc_en = if_id_en = id_ex_en = ex_mem_en = 0; if_id_flush = id_ex_flush = mem_wb_bubble = 1; dmem_req = 0; mem_timeout = 0.
- **Reset mid-MEM_WAIT:** abandons the access with no mem_timeout pulse; the first cycle after reset is RUN.
- **Load-use:** exactly 1 stall cycle. The bubble in ID/EX clears the condition on the next cycle.
- **Memory access:** N stall cycles for ready arriving N cycles after the first request cycle. Timeout gives exactly MEM_TIMEOUT stall cycles, then one release cycle with mem_timeout = 1.
- **Redirect:** the flush is applied in the same cycle ex_redirect is seen (with no mstall), giving a 2-instruction penalty.

## Configuration
- **HAZ_PERF_CNT_EN defined:**
  - stall_cycles increments on every cycle with pc_en = 0 outside reset.
  - flush_events increments on every cycle with if_id_flush = 1 outside reset.
  - Both counters wrap modulo 2^32.
- **HAZ_PERF_CNT_EN undefined:** no counter flops; stall_cycles and flush_events are tied to 0.

## Test plan
- **Load-use:** ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; then normal. Repeat with ex_rd = 0 → no stall.
- **Redirect plus load-use in the same cycle:** ex_redirect = 1 with the load-use match → if_id_flush = 1, id_ex_flush = 1, pc_en = 1; no stall.
- **Memory wait:** mem_access = 1, dmem_ready low 3 cycles then high → 3 cycles with all enables 0 and mem_wb_bubble = 1; release on the 4th cycle; stall_cycles = 3 (macro on).
- **Timeout:** MEM_TIMEOUT = 4, dmem_ready never high → 4 stall cycles, then mem_timeout = 1 for one cycle with mem_wb_bubble = 1, then RUN. Variant: ready on the release cycle → no mem_timeout.
- **Redirect held during mstall:** ex_redirect = 1 during mstall → no flush until the stall releases, then a single flush cycle.
- **Reset in MEM_WAIT:** assert reset after 2 wait cycles → reset output values as specified; RUN, counters 0 afterwards; no mem_timeout.
